// File: rtl/vx_async_op_tracker_pkg.sv
// Shared definitions for the async-op tracker: default sizing, width helper
// and the channel naming used by the issuing units.
package vx_async_op_tracker_pkg;

    localparam int DEF_NUM_WARPS    = 8;
    localparam int DEF_NUM_CHANNELS = 2;

    // clog2 that never returns 0, so a single-entry index still has one bit.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NW_WIDTH = up_clog2(DEF_NUM_WARPS);
    localparam int CH_WIDTH = up_clog2(DEF_NUM_CHANNELS);

    typedef enum logic [0:0] {
        ASYNC_CH_DMA = 1'b0,
        ASYNC_CH_TCU = 1'b1
    } async_ch_e;

endpackage

// File: rtl/vx_async_op_tracker_ch_counter.sv
// Outstanding-op counter for one (warp, channel) pair: saturates at
// MAX_PENDING on the way up and at zero on the way down.
module vx_async_op_tracker_ch_counter
    import vx_async_op_tracker_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    localparam int CW = $clog2(MAX_PENDING + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero,
    output logic next_zero,
    output logic underflow
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign full      = (count_q >= CW'(MAX_PENDING));
    assign zero      = (count_q == '0);
    // An issue landing in the same cycle covers the completion, so only a
    // lone completion against an empty counter is an error.
    assign underflow = dec & ~inc & zero;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && !full) begin
            count_d = count_q + CW'(1);
        end else if (dec && !inc && !zero) begin
            count_d = count_q - CW'(1);
        end
    end

    assign next_zero = (count_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vx_async_op_tracker.sv
// Per-warp, per-channel tracker of in-flight async operations with fences,
// driving the scheduler stall vector.
module vx_async_op_tracker
    import vx_async_op_tracker_pkg::*;
#(
    parameter int NUM_WARPS     = DEF_NUM_WARPS,
    parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
    parameter int MAX_PENDING   = 4,
    parameter bit STALL_ON_FULL = 1'b1,
    localparam int NW_BITS = up_clog2(NUM_WARPS),
    localparam int CH_BITS = up_clog2(NUM_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [NW_BITS-1:0]                issue_wid,
    input  logic [CH_BITS-1:0]                issue_ch,
    input  logic [NUM_CHANNELS-1:0]           done_valid,
    input  logic [NUM_CHANNELS*NW_BITS-1:0]   done_wid,
    input  logic                              fence_valid,
    input  logic [NW_BITS-1:0]                fence_wid,
    input  logic [NUM_CHANNELS-1:0]           fence_mask,
    output logic [NUM_WARPS-1:0]              fence_done,
    output logic [NUM_WARPS-1:0]              warp_stall,
    output logic [NUM_WARPS-1:0]              warp_busy,
    output logic                              underflow_err
);

    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] full;
    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] zero;
    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] next_zero;
    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] uflow;

    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] fmask_q;
    logic [NUM_WARPS-1:0][NUM_CHANNELS-1:0] fmask_d;
    logic [NUM_WARPS-1:0]                   fdone_q;
    logic [NUM_WARPS-1:0]                   fdone_d;
    logic                                   uflow_q;

    logic issue_fire;

    // Handshake: an op transfers when issue_valid && issue_ready on a clock
    // edge; issue_ready depends only on the addressed counter, never on
    // issue_valid or on completions in the same cycle.
    assign issue_ready = ~full[issue_wid][issue_ch];
    assign issue_fire  = issue_valid & issue_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
            logic inc;
            logic dec;

            assign inc = issue_fire && (issue_wid == NW_BITS'(w)) && (issue_ch == CH_BITS'(c));
            assign dec = done_valid[c] && (done_wid[c*NW_BITS +: NW_BITS] == NW_BITS'(w));

            vx_async_op_tracker_ch_counter #(
                .MAX_PENDING (MAX_PENDING)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc),
                .dec       (dec),
                .full      (full[w][c]),
                .zero      (zero[w][c]),
                .next_zero (next_zero[w][c]),
                .underflow (uflow[w][c])
            );
        end
    end

    // A fence resolves against next-state counts, so a warp whose last op
    // completes (or that was already idle) never shows a registered fence.
    always_comb begin
        logic [NUM_CHANNELS-1:0] pend;
        logic                    hit;
        logic                    clear;
        fmask_d = fmask_q;
        fdone_d = '0;
        pend    = '0;
        hit     = 1'b0;
        clear   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            hit   = fence_valid && (fence_wid == NW_BITS'(w));
            pend  = fmask_q[w] | (hit ? fence_mask : '0);
            clear = ~|(pend & ~next_zero[w]);
            fmask_d[w] = clear ? '0 : pend;
            fdone_d[w] = clear && ((pend != '0) || hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fmask_q <= '0;
            fdone_q <= '0;
            uflow_q <= 1'b0;
        end else begin
            fmask_q <= fmask_d;
            fdone_q <= fdone_d;
            if (|uflow) begin
                uflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        warp_stall = '0;
        warp_busy  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_stall[w] = (|fmask_q[w]) | (STALL_ON_FULL & (|full[w]));
            warp_busy[w]  = ~&zero[w];
        end
    end

    assign fence_done    = fdone_q;
    assign underflow_err = uflow_q;

endmodule

// File: tb/tb_vx_async_op_tracker.sv
// Randomized and directed checks of vx_async_op_tracker against a
// count-array reference model.
module tb_vx_async_op_tracker;

    localparam int NW  = 8;
    localparam int NC  = 2;
    localparam int MAX = 4;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    issue_wid;
    logic [0:0]    issue_ch;
    logic [1:0]    done_valid;
    logic [5:0]    done_wid;
    logic          fence_valid;
    logic [2:0]    fence_wid;
    logic [1:0]    fence_mask;
    logic [NW-1:0] fence_done;
    logic [NW-1:0] warp_stall;
    logic [NW-1:0] warp_busy;
    logic          underflow_err;

    vx_async_op_tracker #(
        .NUM_WARPS     (NW),
        .NUM_CHANNELS  (NC),
        .MAX_PENDING   (MAX),
        .STALL_ON_FULL (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_wid     (issue_wid),
        .issue_ch      (issue_ch),
        .done_valid    (done_valid),
        .done_wid      (done_wid),
        .fence_valid   (fence_valid),
        .fence_wid     (fence_wid),
        .fence_mask    (fence_mask),
        .fence_done    (fence_done),
        .warp_stall    (warp_stall),
        .warp_busy     (warp_busy),
        .underflow_err (underflow_err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model
    int       mcnt [NW][NC];
    bit [1:0] mfmask [NW];
    bit [NW-1:0] mdone;
    bit       muf;

    int vectors = 0;
    int errors  = 0;

    task automatic model_clear();
        for (int w = 0; w < NW; w++) begin
            for (int c = 0; c < NC; c++) mcnt[w][c] = 0;
            mfmask[w] = '0;
        end
        mdone = '0;
        muf   = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input int iw, input int ic);
        logic [NW-1:0] es;
        logic [NW-1:0] eb;
        for (int w = 0; w < NW; w++) begin
            es[w] = (mfmask[w] != 0) || (mcnt[w][0] == MAX) || (mcnt[w][1] == MAX);
            eb[w] = (mcnt[w][0] != 0) || (mcnt[w][1] != 0);
        end
        check("issue_ready", {31'b0, issue_ready}, {31'b0, mcnt[iw][ic] < MAX});
        check("warp_stall", {24'b0, warp_stall}, {24'b0, es});
        check("warp_busy", {24'b0, warp_busy}, {24'b0, eb});
        check("fence_done", {24'b0, fence_done}, {24'b0, mdone});
        check("underflow_err", {31'b0, underflow_err}, {31'b0, muf});
    endtask

    // driver: one cycle of stimulus, model compare before the edge, model
    // advance at the edge
    task automatic step(input bit iv, input int iw, input int ic,
                        input bit [1:0] dv, input int d0, input int d1,
                        input bit fv, input int fw, input bit [1:0] fm);
        int       ncnt [NW][NC];
        bit [1:0] nf [NW];
        bit [NW-1:0] nd;
        bit       nuf;
        bit       fire;
        int       dw [NC];
        @(negedge clk);
        reset       = 1'b0;
        issue_valid = iv;
        issue_wid   = 3'(iw);
        issue_ch    = 1'(ic);
        done_valid  = dv;
        done_wid    = {3'(d1), 3'(d0)};
        fence_valid = fv;
        fence_wid   = 3'(fw);
        fence_mask  = fm;
        #1;
        compare_all(iw, ic);
        vectors++;
        dw[0] = d0;
        dw[1] = d1;
        fire = iv && (mcnt[iw][ic] < MAX);
        nuf  = muf;
        for (int w = 0; w < NW; w++) begin
            for (int c = 0; c < NC; c++) begin
                bit inc;
                bit dec;
                inc = fire && (iw == w) && (ic == c);
                dec = dv[c] && (dw[c] == w);
                ncnt[w][c] = mcnt[w][c];
                if (dec && !inc) begin
                    if (mcnt[w][c] == 0) nuf = 1'b1;
                    else ncnt[w][c] = mcnt[w][c] - 1;
                end else if (inc && !dec) begin
                    ncnt[w][c] = mcnt[w][c] + 1;
                end
            end
        end
        for (int w = 0; w < NW; w++) begin
            bit [1:0] pend;
            bit hit;
            bit drained;
            hit  = fv && (fw == w);
            pend = mfmask[w] | (hit ? fm : 2'b00);
            drained = 1'b1;
            for (int c = 0; c < NC; c++)
                if (pend[c] && ncnt[w][c] != 0) drained = 1'b0;
            nf[w] = drained ? 2'b00 : pend;
            nd[w] = drained && (pend != 0 || hit);
        end
        @(posedge clk);
        mcnt   = ncnt;
        mfmask = nf;
        mdone  = nd;
        muf    = nuf;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        issue_valid = 1'b0;
        done_valid  = '0;
        fence_valid = 1'b0;
        @(posedge clk);
        model_clear();
        vectors++;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_wid   = '0;
        issue_ch    = '0;
        done_valid  = '0;
        done_wid    = '0;
        fence_valid = 1'b0;
        fence_wid   = '0;
        fence_mask  = '0;
        model_clear();
        do_reset();

        // reset state
        check("rst_stall", {24'b0, warp_stall}, 32'h0);
        check("rst_busy", {24'b0, warp_busy}, 32'h0);
        check("rst_fdone", {24'b0, fence_done}, 32'h0);
        check("rst_uf", {31'b0, underflow_err}, 32'h0);
        check("rst_ready", {31'b0, issue_ready}, 32'h1);

        // fill w1 c0 to MAX
        for (int i = 0; i < 4; i++) step(1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00);
        check("full_ready", {31'b0, issue_ready}, 32'h0);
        check("full_stall1", {31'b0, warp_stall[1]}, 32'h1);
        step(0, 1, 0, 2'b01, 1, 0, 0, 0, 2'b00);
        check("unfull_stall1", {31'b0, warp_stall[1]}, 32'h0);
        check("unfull_ready", {31'b0, issue_ready}, 32'h1);

        // fence on w2 channel 0 only
        step(1, 2, 0, 2'b00, 0, 0, 0, 0, 2'b00);
        step(1, 2, 1, 2'b00, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00, 0, 0, 1, 2, 2'b01);
        check("fence_stall2", {31'b0, warp_stall[2]}, 32'h1);
        check("fence_nodone2", {31'b0, fence_done[2]}, 32'h0);
        step(0, 0, 0, 2'b01, 2, 0, 0, 0, 2'b00);
        check("fence_done2", {31'b0, fence_done[2]}, 32'h1);
        check("fence_unstall2", {31'b0, warp_stall[2]}, 32'h0);
        check("fence_busy2", {31'b0, warp_busy[2]}, 32'h1);
        step(0, 0, 0, 2'b10, 0, 2, 0, 0, 2'b00);
        check("fence_pulse2", {31'b0, fence_done[2]}, 32'h0);
        check("idle_busy2", {31'b0, warp_busy[2]}, 32'h0);

        // simultaneous issue and completion on w3 c1 at count 2
        step(1, 3, 1, 2'b00, 0, 0, 0, 0, 2'b00);
        step(1, 3, 1, 2'b00, 0, 0, 0, 0, 2'b00);
        step(1, 3, 1, 2'b10, 0, 3, 0, 0, 2'b00);
        check("same_stall3", {31'b0, warp_stall[3]}, 32'h0);
        check("same_busy3", {31'b0, warp_busy[3]}, 32'h1);
        step(0, 0, 0, 2'b10, 0, 3, 0, 0, 2'b00);
        check("drain1_busy3", {31'b0, warp_busy[3]}, 32'h1);
        step(0, 0, 0, 2'b10, 0, 3, 0, 0, 2'b00);
        check("drain2_busy3", {31'b0, warp_busy[3]}, 32'h0);
        check("drain2_uf", {31'b0, underflow_err}, 32'h0);

        // fence on idle warp
        step(0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b11);
        check("idle_fence_stall0", {31'b0, warp_stall[0]}, 32'h0);
        check("idle_fence_done0", {31'b0, fence_done[0]}, 32'h1);
        idle();
        check("idle_fence_once0", {31'b0, fence_done[0]}, 32'h0);

        // underflow on w5
        step(0, 0, 0, 2'b01, 5, 0, 0, 0, 2'b00);
        check("uf_set", {31'b0, underflow_err}, 32'h1);
        check("uf_busy5", {31'b0, warp_busy[5]}, 32'h0);
        idle();
        check("uf_sticky", {31'b0, underflow_err}, 32'h1);

        // reset with pending counts and an active fence
        step(1, 4, 0, 2'b00, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00, 0, 0, 1, 4, 2'b01);
        check("pre_rst_stall4", {31'b0, warp_stall[4]}, 32'h1);
        do_reset();
        check("mid_rst_stall", {24'b0, warp_stall}, 32'h0);
        check("mid_rst_busy", {24'b0, warp_busy}, 32'h0);
        check("mid_rst_fdone", {24'b0, fence_done}, 32'h0);
        check("mid_rst_uf", {31'b0, underflow_err}, 32'h0);
        check("mid_rst_ready", {31'b0, issue_ready}, 32'h1);

        // randomized traffic concentrated on a few warps
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                bit [1:0] dv;
                bit fv;
                dv[0] = ($urandom_range(0, 99) < 30);
                dv[1] = ($urandom_range(0, 99) < 30);
                fv    = ($urandom_range(0, 99) < 8);
                step($urandom_range(0, 99) < 55, $urandom_range(0, 3), $urandom_range(0, 1),
                     dv, $urandom_range(0, 3), $urandom_range(0, 3),
                     fv, $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
